// File: rtl/rne_residual_fix_if.sv
`default_nettype none
// ============================================================================
// rne_residual_fix_if : request/result bundle for the RNE residual checker
// Revision: 1.0
// ============================================================================
interface rne_residual_fix_if #(
  parameter int W = 16
);
  logic           start;
  logic [W-1:0]   q_in;
  logic [W-1:0]   d_in;
  logic [2*W-1:0] n_in;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   q_out;
  logic           ovf;
  logic           dz;

  modport master (
    output start, q_in, d_in, n_in, out_ready,
    input  busy, out_valid, q_out, ovf, dz
  );

  modport slave (
    input  start, q_in, d_in, n_in, out_ready,
    output busy, out_valid, q_out, ovf, dz
  );
endinterface
`default_nettype wire

// File: rtl/rne_residual_fix.sv
`default_nettype none
// ============================================================================
// rne_residual_fix : multiplies back Q*D serially and nudges Q by one so it
//                    becomes the round-to-nearest-even quotient of N/D
// Revision: 1.0
// ============================================================================
module rne_residual_fix #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rne_residual_fix_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int            CW     = $clog2(W + 1);
  localparam int            RW     = 2 * W + 3;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  state_t           r_state;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_d;
  logic [2*W-1:0]   r_n;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_qsh;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_valid;
  logic [W-1:0]     r_q_out;
  logic             r_ovf;
  logic             r_dz;

  logic signed [RW-1:0] w_r2;
  logic signed [RW-1:0] w_dpos;
  logic signed [RW-1:0] w_dneg;
  logic                 w_inc;
  logic                 w_dec;
  logic                 w_dz;
  logic                 w_sat;
  logic [W-1:0]         w_qnext;

  // 2R = 2(N - P) carried with enough headroom that neither sign nor doubling overflows
  assign w_r2   = ($signed({3'b000, r_n}) - $signed({3'b000, r_acc})) <<< 1;
  assign w_dpos = $signed({{(W + 3){1'b0}}, r_d});
  assign w_dneg = -w_dpos;

  // On an exact tie, moving only when Q is odd lands on the even neighbour
  assign w_inc = (w_r2 > w_dpos) | ((w_r2 == w_dpos) & r_q[0]);
  assign w_dec = (w_r2 < w_dneg) | ((w_r2 == w_dneg) & r_q[0]);
  assign w_dz  = (r_d == '0);
  assign w_sat = ~w_dz & ((w_inc & (&r_q)) | (w_dec & (r_q == '0)));

  always_comb begin
    w_qnext = r_q;
    if (!w_dz && !w_sat) begin
      if (w_inc) begin
        w_qnext = r_q + W'(1);
      end else if (w_dec) begin
        w_qnext = r_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_n     <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_qsh   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_q_out <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_q     <= bus.q_in;
            r_d     <= bus.d_in;
            r_n     <= bus.n_in;
            r_acc   <= '0;
            r_mcand <= {{W{1'b0}}, bus.d_in};
            r_qsh   <= bus.q_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (r_qsh[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_qsh   <= r_qsh >> 1;
          if (r_cnt == C_LAST) begin
            r_state <= CMP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        CMP: begin
          r_q_out <= w_qnext;
          r_ovf   <= w_sat;
          r_dz    <= w_dz;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.q_out     = r_q_out;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_rne_residual_fix.sv
`default_nettype none
// ============================================================================
// tb_rne_residual_fix : directed and constrained-random checks of the RNE fixer
// Revision: 1.0
// ============================================================================
module tb_rne_residual_fix;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;

  rne_residual_fix_if #(.W(W)) bus ();

  rne_residual_fix #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  bit armed    = 1'b0;

  logic [W-1:0] exp_q;
  logic         exp_ovf;
  logic         exp_dz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer division with ties to even, then saturation when unrepresentable
  function automatic logic [W+1:0] model(input logic [W-1:0] q, input logic [W-1:0] d,
                                         input logic [2*W-1:0] n);
    longint quo;
    longint rem;
    if (d == '0) return {q, 1'b0, 1'b1};
    quo = longint'(n) / longint'(d);
    rem = longint'(n) % longint'(d);
    if ((2 * rem > longint'(d)) || ((2 * rem == longint'(d)) && (quo % 2 == 1))) quo++;
    if (quo > longint'((1 << W) - 1)) return {q, 1'b1, 1'b0};
    return {quo[W-1:0], 2'b00};
  endfunction

  // Single compare process: timing, busy and result while an operation is in flight
  always @(negedge clk) begin
    if (rst_n && armed) begin
      int el;
      el = cyc - start_cyc;
      check("busy_in_flight", bus.busy, 1);
      check("valid_timing", bus.out_valid, (el >= LAT) ? 1 : 0);
      if (bus.out_valid) begin
        check("q_out", bus.q_out, exp_q);
        check("ovf", bus.ovf, exp_ovf);
        check("dz", bus.dz, exp_dz);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d,
                        input logic [2*W-1:0] n, input int hold, input bit pulse);
    logic [W+1:0] m;
    bit seen;
    m = model(q, d, n);
    exp_q   = m[W+1:2];
    exp_ovf = m[1];
    exp_dz  = m[0];
    @(negedge clk);
    bus.start     = 1'b1;
    bus.q_in      = q;
    bus.d_in      = d;
    bus.n_in      = n;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    armed     = 1'b1;
    bus.start = 1'b0;
    bus.q_in  = W'($urandom);
    bus.d_in  = W'($urandom);
    bus.n_in  = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      bus.start = pulse && (i == 4);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    check("valid_seen", seen, 1);
    check("latency", cyc - start_cyc, LAT);
    for (int i = 0; i < hold; i++) begin
      bus.start = pulse && (i == 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.start     = pulse;
    @(posedge clk);
    #1;
    armed         = 1'b0;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("idle_busy", bus.busy, 0);
    check("idle_valid", bus.out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.q_in      = '0;
    bus.d_in      = '0;
    bus.n_in      = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_q_out", bus.q_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_dz", bus.dz, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed values pin the reference model itself
    check("pin_exact",  model(16'd3, 16'd10, 32'd30), {16'd3, 2'b00});
    check("pin_up",     model(16'd3, 16'd10, 32'd36), {16'd4, 2'b00});
    check("pin_tie_up", model(16'd3, 16'd10, 32'd35), {16'd4, 2'b00});
    check("pin_tie_dn", model(16'd3, 16'd10, 32'd25), {16'd2, 2'b00});
    check("pin_sat",    model(16'hFFFF, 16'd1, 32'h0001_0001), {16'hFFFF, 2'b10});
    check("pin_dz",     model(16'h1234, 16'd0, 32'd77), {16'h1234, 2'b01});

    run_op(16'd3, 16'd10, 32'd30, 0, 1'b0);
    run_op(16'd3, 16'd10, 32'd36, 0, 1'b0);
    run_op(16'd3, 16'd10, 32'd24, 0, 1'b0);
    run_op(16'd3, 16'd10, 32'd35, 0, 1'b0);
    run_op(16'd3, 16'd10, 32'd25, 0, 1'b0);
    run_op(16'd4, 16'd10, 32'd45, 0, 1'b0);
    run_op(16'hFFFF, 16'd1, 32'h0001_0001, 0, 1'b0);
    run_op(16'h1234, 16'd0, 32'd77, 0, 1'b0);
    run_op(16'd3, 16'd10, 32'd36, 5, 1'b1);

    // Abort in the middle of the multiply, then confirm a clean restart
    @(negedge clk);
    bus.start = 1'b1;
    bus.q_in  = 16'd7;
    bus.d_in  = 16'd9;
    bus.n_in  = 32'd70;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_q_out", bus.q_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd3, 16'd10, 32'd36, 0, 1'b0);

    for (int k = 0; k < 600; k++) begin
      logic [W-1:0] q;
      logic [W-1:0] d;
      longint off;
      longint nn;
      q = W'($urandom);
      if (k % 50 == 7)  q = 16'hFFFF;
      if (k % 50 == 13) q = 16'h0000;
      d = W'($urandom_range(1, 65535));
      off = longint'($urandom_range(0, 2 * int'(d) - 2)) - longint'(d) + 1;
      if (($urandom_range(0, 7) == 0) && (d[0] == 1'b0))
        off = ($urandom_range(0, 1) == 1) ? longint'(d) / 2 : -(longint'(d) / 2);
      nn = longint'(q) * longint'(d) + off;
      if (nn < 0) nn = -nn;
      run_op(q, d, nn[2*W-1:0], k % 3, k[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
